// File: rtl/dll_dcntl_update_ctrl.sv
// DLL control-code manager: lock qualification, update scheduling,
// stable-code capture and slew-limited forwarding to slave delay lines.
module dll_dcntl_update_ctrl #(
    parameter int unsigned LOCK_QUAL_CNT = 16,
    parameter int unsigned UPD_INTERVAL  = 1024,
    parameter int unsigned UPD_PULSE_W   = 4,
    parameter int unsigned SETTLE_CNT    = 8,
    parameter int unsigned MAX_STEP      = 4,
    parameter int unsigned RETRY_MAX     = 3
) (
    input  logic       CLKI,
    input  logic       RST,
    input  logic       LOCK,
    input  logic [8:0] DCNTL,
    input  logic       UPD_REQ,
    input  logic       FREEZE,
    output logic       UDDCNTL,
    output logic [8:0] DCNTL_OUT,
    output logic       DCNTL_VALID,
    output logic       UPD_BUSY,
    output logic       ERR
);

    typedef enum logic [2:0] {
        IDLE, QUAL, READY, UPDATE, SETTLE, CAPA, CAPB
    } state_t;

    localparam logic [15:0] QUAL_N      = 16'(LOCK_QUAL_CNT);
    localparam logic [15:0] INT_LAST    = 16'(UPD_INTERVAL - 1);
    localparam logic [15:0] PULSE_LAST  = 16'(UPD_PULSE_W - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CNT - 1);
    localparam logic [7:0]  RETRY_N     = 8'(RETRY_MAX);
    localparam logic signed [9:0] STEP  = 10'(MAX_STEP);
    localparam logic [8:0]  STEP9       = 9'(MAX_STEP);

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic        lock_s;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] int_q, int_d;
    logic [7:0]  retry_q, retry_d;
    logic        pend_q, pend_d;
    logic [8:0]  samp_q, samp_d;
    logic [8:0]  out_q, out_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        upd_q, upd_d;
    logic        busy_q, busy_d;
    logic signed [9:0] diff;
    logic [8:0]  slew_val;

    assign lock_s = sync_q[1];
    assign diff   = $signed({1'b0, DCNTL}) - $signed({1'b0, out_q});

    // First code after (re)lock is taken as-is; later ones are slew-limited
    always_comb begin
        slew_val = DCNTL;
        if (valid_q && diff > STEP) begin
            slew_val = out_q + STEP9;
        end else if (valid_q && diff < -STEP) begin
            slew_val = out_q - STEP9;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        int_d   = int_q;
        retry_d = retry_q;
        pend_d  = pend_q;
        samp_d  = samp_q;
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (state_q != IDLE && !lock_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            int_d   = '0;
            retry_d = '0;
            pend_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lock_s) begin
                        if (QUAL_N <= 16'd1) begin
                            state_d = UPDATE;
                            cnt_d   = '0;
                        end else begin
                            state_d = QUAL;
                            cnt_d   = 16'd1;
                        end
                    end
                end
                QUAL: begin
                    if (cnt_q + 16'd1 >= QUAL_N) begin
                        state_d = UPDATE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                READY: begin
                    if (!FREEZE && (int_q == INT_LAST || UPD_REQ || pend_q)) begin
                        state_d = UPDATE;
                        cnt_d   = '0;
                        int_d   = '0;
                        pend_d  = 1'b0;
                    end else if (!FREEZE) begin
                        int_d = int_q + 16'd1;
                    end
                end
                UPDATE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = CAPA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                CAPA: begin
                    samp_d  = DCNTL;
                    state_d = CAPB;
                end
                CAPB: begin
                    if (DCNTL == samp_q) begin
                        out_d   = slew_val;
                        valid_d = 1'b1;
                        retry_d = '0;
                        int_d   = '0;
                        state_d = READY;
                    end else if (retry_q + 8'd1 == RETRY_N) begin
                        err_d   = 1'b1;
                        retry_d = '0;
                        state_d = READY;
                    end else begin
                        retry_d = retry_q + 8'd1;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (UPD_REQ && state_q inside {UPDATE, SETTLE, CAPA, CAPB}) begin
                pend_d = 1'b1;
            end
        end
        upd_d  = (state_d == UPDATE);
        busy_d = state_d inside {UPDATE, SETTLE, CAPA, CAPB};
    end

    always_ff @(posedge CLKI or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            int_q   <= '0;
            retry_q <= '0;
            pend_q  <= 1'b0;
            samp_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], LOCK};
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            retry_q <= retry_d;
            pend_q  <= pend_d;
            samp_q  <= samp_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
        end
    end

    assign UDDCNTL     = upd_q;
    assign DCNTL_OUT   = out_q;
    assign DCNTL_VALID = valid_q;
    assign UPD_BUSY    = busy_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_dll_dcntl_update_ctrl.sv
// Directed and randomized checks of dll_dcntl_update_ctrl against a
// cycle-count and slew-arithmetic reference model.
module tb_dll_dcntl_update_ctrl;

    logic       CLKI = 1'b0;
    logic       RST;
    logic       LOCK;
    logic [8:0] DCNTL;
    logic       UPD_REQ;
    logic       FREEZE;
    logic       UDDCNTL;
    logic [8:0] DCNTL_OUT;
    logic       DCNTL_VALID;
    logic       UPD_BUSY;
    logic       ERR;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    dll_dcntl_update_ctrl dut (
        .CLKI(CLKI), .RST(RST), .LOCK(LOCK), .DCNTL(DCNTL),
        .UPD_REQ(UPD_REQ), .FREEZE(FREEZE), .UDDCNTL(UDDCNTL),
        .DCNTL_OUT(DCNTL_OUT), .DCNTL_VALID(DCNTL_VALID),
        .UPD_BUSY(UPD_BUSY), .ERR(ERR)
    );

    always #5 CLKI = ~CLKI;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference slew rule: plain integer arithmetic on the code values
    function automatic logic [8:0] slew(input logic [8:0] cur,
                                        input bit v, input logic [8:0] b);
        int d;
        d = int'(b) - int'(cur);
        if (!v) return b;
        if (d > 4) return 9'(int'(cur) + 4);
        if (d < -4) return 9'(int'(cur) - 4);
        return b;
    endfunction

    task automatic wait_upd(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            @(negedge CLKI);
            n++;
            if (UDDCNTL === 1'b1) return;
        end
    endtask

    // Sample index j is the cycle after edge k+j, k = request edge
    task automatic seq(input bit do_req, input int total, input bit tog,
                       input bit req2, output logic [63:0] ub,
                       output bit ball, output bit held);
        logic [8:0] start;
        ub = '0;
        ball = 1'b1;
        held = 1'b1;
        start = DCNTL_OUT;
        if (do_req) begin
            UPD_REQ = 1'b1;
            @(negedge CLKI);
            UPD_REQ = 1'b0;
        end
        for (int j = 0; j < total; j++) begin
            ub[j] = UDDCNTL;
            if (UPD_BUSY !== 1'b1) ball = 1'b0;
            if (DCNTL_OUT !== start) held = 1'b0;
            if (req2) UPD_REQ = (j == 1);
            if (tog) DCNTL = DCNTL ^ 9'd1;
            @(negedge CLKI);
        end
        UPD_REQ = 1'b0;
    endtask

    task automatic update(input string tag, input bit do_req,
                          input bit req2, input logic [8:0] exp);
        logic [63:0] ub;
        bit ball, held;
        seq(do_req, 14, 1'b0, req2, ub, ball, held);
        chk({tag, "_pulse"}, ub, 64'hF);
        chk({tag, "_busy"}, 64'(ball), 64'd1);
        chk({tag, "_held"}, 64'(held), 64'd1);
        chk({tag, "_out"}, 64'(DCNTL_OUT), 64'(exp));
        chk({tag, "_valid"}, 64'(DCNTL_VALID), 64'd1);
        chk({tag, "_idle"}, 64'(UPD_BUSY), 64'd0);
    endtask

    initial begin
        logic [8:0] cur, exp;
        logic [63:0] ub;
        bit ball, held, flag;
        int n, it;

        RST = 1'b1;
        LOCK = 1'b0;
        UPD_REQ = 1'b0;
        FREEZE = 1'b0;
        DCNTL = 9'd200;
        repeat (3) @(negedge CLKI);
        chk("reset_outs", {UDDCNTL, DCNTL_OUT, DCNTL_VALID, UPD_BUSY, ERR}, 0);
        RST = 1'b0;
        repeat (3) @(negedge CLKI);
        chk("unlocked_quiet", {UDDCNTL, UPD_BUSY}, 0);

        LOCK = 1'b1;
        wait_upd(60, n);
        chk("qual_latency", n, 18);
        update("first", 1'b0, 1'b0, 9'd200);
        cur = 9'd200;

        DCNTL = 9'd198;
        exp = slew(cur, 1'b1, DCNTL);
        update("down", 1'b1, 1'b0, exp);
        cur = exp;
        DCNTL = 9'd200;
        exp = slew(cur, 1'b1, DCNTL);
        update("back", 1'b1, 1'b0, exp);
        cur = exp;
        DCNTL = 9'd210;
        for (int i = 0; i < 3; i++) begin
            exp = slew(cur, 1'b1, DCNTL);
            update("slew_up", 1'b1, 1'b0, exp);
            cur = exp;
        end
        for (int i = 0; i < 6; i++) begin
            DCNTL = 9'($urandom_range(0, 511));
            exp = slew(cur, 1'b1, DCNTL);
            update("rand", 1'b1, 1'b0, exp);
            cur = exp;
        end

        DCNTL = 9'($urandom_range(0, 511));
        exp = slew(cur, 1'b1, DCNTL);
        update("pend_a", 1'b1, 1'b1, exp);
        cur = exp;
        @(negedge CLKI);
        chk("pend_restart", 64'(UDDCNTL), 64'd1);
        exp = slew(cur, 1'b1, DCNTL);
        update("pend_b", 1'b0, 1'b0, exp);
        cur = exp;

        FREEZE = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            UPD_REQ = (i == 500);
            @(negedge CLKI);
            if (UDDCNTL !== 1'b0 || UPD_BUSY !== 1'b0) flag = 1'b1;
        end
        UPD_REQ = 1'b0;
        chk("freeze_quiet", 64'(flag), 64'd0);
        FREEZE = 1'b0;
        flag = 1'b0;
        repeat (5) begin
            @(negedge CLKI);
            if (UDDCNTL !== 1'b0) flag = 1'b1;
        end
        chk("freeze_req_dropped", 64'(flag), 64'd0);

        DCNTL = 9'($urandom_range(0, 511));
        exp = slew(cur, 1'b1, DCNTL);
        update("pre_int", 1'b1, 1'b0, exp);
        cur = exp;
        DCNTL = 9'($urandom_range(0, 511));
        n = 0;
        while (n < 1100) begin
            @(negedge CLKI);
            n++;
            UPD_REQ = (n == 1023);
            if (UDDCNTL === 1'b1) break;
        end
        UPD_REQ = 1'b0;
        chk("interval_len", n, 1024);
        exp = slew(cur, 1'b1, DCNTL);
        update("interval", 1'b0, 1'b0, exp);
        cur = exp;
        flag = 1'b0;
        repeat (20) begin
            @(negedge CLKI);
            if (UDDCNTL !== 1'b0) flag = 1'b1;
        end
        chk("coincide_single", 64'(flag), 64'd0);

        DCNTL = 9'd100;
        seq(1'b1, 34, 1'b1, 1'b0, ub, ball, held);
        chk("unstable_pulse", ub, 64'hF);
        chk("unstable_busy", 64'(ball), 64'd1);
        chk("unstable_held", 64'(held), 64'd1);
        chk("unstable_err", 64'(ERR), 64'd1);
        chk("unstable_ready", 64'(UPD_BUSY), 64'd0);
        chk("unstable_out", 64'(DCNTL_OUT), 64'(cur));
        DCNTL = 9'd101;
        exp = slew(cur, 1'b1, DCNTL);
        update("after_err", 1'b1, 1'b0, exp);
        cur = exp;
        chk("err_sticky", 64'(ERR), 64'd1);

        DCNTL = 9'd200;
        it = 0;
        while (cur !== 9'd200 && it < 140) begin
            exp = slew(cur, 1'b1, DCNTL);
            update("converge", 1'b1, 1'b0, exp);
            cur = exp;
            it++;
        end
        chk("converged", 64'(DCNTL_OUT), 64'd200);

        UPD_REQ = 1'b1;
        @(negedge CLKI);
        UPD_REQ = 1'b0;
        repeat (6) @(negedge CLKI);
        LOCK = 1'b0;
        repeat (3) @(negedge CLKI);
        chk("lossy_outs", {UDDCNTL, UPD_BUSY, DCNTL_VALID}, 0);
        chk("lossy_hold", 64'(DCNTL_OUT), 64'd200);
        chk("lossy_err", 64'(ERR), 64'd1);
        repeat (3) @(negedge CLKI);
        DCNTL = 9'd50;
        LOCK = 1'b1;
        wait_upd(60, n);
        chk("relock_latency", n, 18);
        exp = slew(9'd200, 1'b0, DCNTL);
        update("relock", 1'b0, 1'b0, exp);

        UPD_REQ = 1'b1;
        @(negedge CLKI);
        UPD_REQ = 1'b0;
        chk("pre_rst_pulse", 64'(UDDCNTL), 64'd1);
        #2 RST = 1'b1;
        #1;
        chk("async_rst", {UDDCNTL, DCNTL_OUT, UPD_BUSY, DCNTL_VALID, ERR}, 0);
        @(negedge CLKI);
        RST = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dll_dcntl_update_ctrl.md
Name: dll_dcntl_update_ctrl

Overview:
Digital control-code manager that sits beside the DLL. It drives the DLL's UDDCNTL update-enable input and consumes its LOCK and DCNTL[8:0] outputs. It qualifies lock, schedules periodic or requested code updates, and captures DCNTL only when the code is stable. It then forwards a slew-limited code (DCNTL_OUT) to downstream slave delay lines.

Parameters:
LOCK_QUAL_CNT, 16, consecutive synchronized-LOCK-high cycles required before the first update
UPD_INTERVAL, 1024, READY cycles between automatic updates (valid range 2..65535)
UPD_PULSE_W, 4, width of each UDDCNTL pulse in cycles (>=1)
SETTLE_CNT, 8, cycles waited after UDDCNTL falls before sampling DCNTL (>=1)
MAX_STEP, 4, largest change applied to DCNTL_OUT per capture once valid (1..511)
RETRY_MAX, 3, consecutive unstable captures tolerated before ERR sets

Ports:
CLKI  in  1  system clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
LOCK  in  1  DLL lock indication, asynchronous to CLKI
DCNTL  in  9  DLL delay control code, quasi-static
UPD_REQ  in  1  single-cycle software/host update request
FREEZE  in  1  blocks new updates and holds the interval counter
UDDCNTL  out  1  update enable to DLL
DCNTL_OUT  out  9  filtered code to slave delay lines
DCNTL_VALID  out  1  DCNTL_OUT is a code captured during the current lock
UPD_BUSY  out  1  update sequence in progress
ERR  out  1  sticky: RETRY_MAX unstable captures occurred

Behaviour:
- Reset (async assert, sync release):
  - UDDCNTL=0, DCNTL_OUT=0, DCNTL_VALID=0, UPD_BUSY=0, ERR=0.
  - State=IDLE; all counters=0; LOCK synchronizer=00; pending request=0.
- LOCK passes through a 2-flop synchronizer to lock_s; lock_s lags LOCK by 2 cycles.
- States: IDLE, QUAL, READY, UPDATE, SETTLE, CAPA, CAPB.
- Lock loss: lock_s=0 in any state except IDLE sends the block to IDLE on the next edge.
  - UDDCNTL=0, DCNTL_VALID=0, pending request cleared.
  - DCNTL_OUT and ERR are held.
- IDLE: lock_s=1 -> QUAL with qual counter=1.
- QUAL: counter increments while lock_s=1. When the counter reaches LOCK_QUAL_CNT -> UPDATE; this first update is forced regardless of FREEZE.
- READY:
  - Interval counter increments each cycle unless FREEZE=1, in which case it holds.
  - Leave for UPDATE when FREEZE=0 and any of: interval counter = UPD_INTERVAL-1, UPD_REQ=1, or pending=1.
  - UPD_REQ while FREEZE=1 is dropped.
- UPD_REQ in UPDATE/SETTLE/CAPA/CAPB sets pending (one-deep). Pending clears when READY exits to UPDATE.
- UPDATE: UDDCNTL=1 for exactly UPD_PULSE_W cycles -> SETTLE.
- SETTLE: UDDCNTL=0 for SETTLE_CNT cycles -> CAPA.
- CAPA: register DCNTL as sample A -> CAPB.
- CAPB: compare DCNTL (sample B) with A.
  - Equal: apply B, clear the retry counter, reset the interval counter to 0 -> READY.
  - Unequal: increment the retry counter.
    - If retry counter = RETRY_MAX: set ERR, clear the retry counter, leave DCNTL_OUT unchanged -> READY.
    - Otherwise -> SETTLE for another SETTLE_CNT cycles, then resample.
- Apply rule, using a 10-bit signed diff = B - DCNTL_OUT:
  - DCNTL_VALID=0: DCNTL_OUT=B and DCNTL_VALID=1.
  - |diff| <= MAX_STEP: DCNTL_OUT=B.
  - Otherwise: DCNTL_OUT = DCNTL_OUT ± MAX_STEP toward B. This never crosses B, so no wrap outside 0..511.
- Timing:
  - DCNTL_OUT updates on the edge that leaves CAPB.
  - UPD_BUSY=1 exactly in UPDATE, SETTLE, CAPA and CAPB, and is registered together with the state.
- Latency: UPD_REQ sampled in READY at edge k gives UDDCNTL high over cycles k+1..k+UPD_PULSE_W. DCNTL_OUT changes at edge k+UPD_PULSE_W+SETTLE_CNT+2 when stable.
- Simultaneous events:
  - Lock loss has priority over everything.
  - The interval expiring and UPD_REQ in the same cycle produce one update; pending stays 0.
- RST mid-sequence drops UDDCNTL immediately (async).

Test Plan:
- Lock and first capture: after reset, LOCK=1 with DCNTL=9'd200 held → ~2+16 cycles later, UDDCNTL high for 4 cycles; after 8 settle cycles plus 2, DCNTL_OUT=200 and DCNTL_VALID=1.
- Slew limit: DCNTL_OUT=200, DCNTL=210, UPD_REQ pulse → DCNTL_OUT=204. A second request gives 208, a third gives 210. For a downward case with DCNTL=198, DCNTL_OUT goes 200→198 in one step.
- Unstable code: DCNTL toggles 100/101 every cycle during every capture → three SETTLE/capture rounds, then ERR=1, DCNTL_OUT unchanged, return to READY. ERR stays 1 until RST.
- FREEZE and pending:
  - FREEZE=1 for 2000 cycles in READY → no UDDCNTL pulse. UPD_REQ during FREEZE is ignored.
  - UPD_REQ during UPDATE → a second full sequence starts immediately after returning to READY.
- Lock loss: drop LOCK during SETTLE → within 2-3 cycles the state is IDLE, UDDCNTL=0 and DCNTL_VALID=0, with DCNTL_OUT held. On relock with DCNTL=50, DCNTL_OUT loads 50 directly with no slew limit.
- Async reset: assert RST while UDDCNTL=1 → UDDCNTL, DCNTL_OUT and UPD_BUSY go to 0 without any clock edge.
